// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: op codes,
// FSM state codes and small op-decode helpers.
package ex_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide,
// one bit per enabled negedge, on a 2*WIDTH accumulator {upper, lower}.
module iter_muldiv_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 mode_div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q;
  logic               div_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   diff;
  logic               ge;

  // Divide: the partial remainder shifted left with the next dividend bit
  // needs WIDTH+1 bits; compare at that width so a zero divisor still
  // yields an all-ones quotient and returns the dividend as remainder.
  always_comb begin
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    ge     = (rem_sh >= {1'b0, b_q});
    diff   = acc_q[2*WIDTH-2:WIDTH-1] - b_q;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    if (div_q) begin
      if (ge) acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
      else    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_i};
      b_q   <= b_i;
      div_q <= mode_div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: accepts one op, stalls the pipeline
// while the core iterates, then sign-fixes and writes HI/LO.
module ex_muldiv_sequencer
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             bz_q, bz_d;

  logic             accept;
  logic             run;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign run    = (state_q == ST_RUN);
  assign accept = (state_q == ST_IDLE) && start && !flush;

  assign sa    = op_is_signed(op) && opA[WIDTH-1];
  assign sb    = op_is_signed(op) && opB[WIDTH-1];
  assign mag_a = sa ? -opA : opA;
  assign mag_b = sb ? -opB : opB;

  iter_muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .load_i     (accept),
    .step_i     (run && !flush),
    .mode_div_i (op_is_div(op)),
    .a_i        (mag_a),
    .b_i        (mag_b),
    .acc_o      (acc)
  );

  // Product sign and quotient sign share one flag; remainder follows opA.
  assign prod_fix = negq_q ? -acc : acc;
  assign q_fix    = negq_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix    = negr_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    bz_d    = bz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(WIDTH);
          dz_d    = 1'b0;
          div_d   = op_is_div(op);
          negq_d  = sa ^ sb;
          negr_d  = sa;
          bz_d    = op_is_div(op) && (opB == '0);
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          hi_d = r_fix;
          lo_d = bz_q ? '1 : q_fix;
          dz_d = bz_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      bz_q    <= bz_d;
    end
  end

  assign stall    = accept || run;
  assign busy     = run;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed corner cases plus
// random ops compared against plain-arithmetic reference results.
module tb_ex_muldiv_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [1:0]   op;
  logic [W-1:0] opA, opB;
  logic         stall, busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_mis = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dz = 1'b0;

  ex_muldiv_sequencer #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .opA      (opA),
    .opB      (opB),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from the architectural definition of each op.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    logic [63:0] r;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'(sa * sb);
      end
      2'b01: r = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0)                                 r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          ia = $signed(a);
          ib = $signed(b);
          r  = {32'(ia % ib), 32'(ia / ib)};
        end
      end
      default: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int stall_cnt, done_cnt, done_at;
    logic [31:0] hi_c, lo_c;
    logic dz_c;
    r = ref_result(o, a, b);
    stall_cnt = 0;
    done_cnt  = 0;
    done_at   = -1;
    hi_c = '0; lo_c = '0; dz_c = 1'b0;
    @(posedge clock);
    start = 1'b1; op = o; opA = a; opB = b;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (stall) stall_cnt++;
      if (c == 1) begin
        chk("busy_run", 64'(busy), 64'd1);
        chk("dz_clr", 64'(div_zero), 64'd0);
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          hi_c = hi; lo_c = lo; dz_c = div_zero;
        end
      end
      if (!stall) start = 1'b0;
      if (done_at >= 0 && c >= done_at + 1) break;
      @(posedge clock);
    end
    start = 1'b0;
    chk("latency", 64'(done_at), 64'(W + 2));
    chk("stall_cycles", 64'(stall_cnt), 64'(W + 1));
    chk("done_width", 64'(done_cnt), 64'd1);
    chk("hi", 64'(hi_c), 64'(r[63:32]));
    chk("lo", 64'(lo_c), 64'(r[31:0]));
    chk("div_zero", 64'(dz_c), 64'(o[1] && b == 32'h0));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    exp_dz = o[1] && (b == 32'h0);
  endtask

  task automatic flush_mid(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int k);
    int done_cnt;
    done_cnt = 0;
    @(posedge clock);
    start = 1'b1; op = o; opA = a; opB = b;
    repeat (k) @(posedge clock);
    start = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_busy_before", 64'(busy), 64'd1);
    @(posedge clock);
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      #1;
      if (done) done_cnt++;
    end
    chk("flush_no_done", 64'(done_cnt), 64'd0);
    chk("flush_hi", 64'(hi), 64'(exp_hi));
    chk("flush_lo", 64'(lo), 64'(exp_lo));
    exp_dz = 1'b0;
    chk("flush_dz", 64'(div_zero), 64'(exp_dz));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    opA   = '0;
    opB   = '0;
    #2;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_flags", {60'd0, busy, stall, done, div_zero}, 64'd0);
    repeat (2) @(posedge clock);
    reset = 1'b1;

    run_op(2'b01, 32'h0000_FFFF, 32'h0000_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b11, 32'd5, 32'd0);

    // start together with flush in IDLE must be dropped entirely
    @(posedge clock);
    start = 1'b1; flush = 1'b1; op = 2'b01; opA = 32'd3; opB = 32'd4;
    #1;
    chk("sf_stall", 64'(stall), 64'd0);
    @(posedge clock);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("sf_busy", 64'(busy), 64'd0);
    chk("sf_dz_kept", 64'(div_zero), 64'(exp_dz));

    run_op(2'b00, 32'h1111_1111, 32'h0000_0001);
    flush_mid(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 10);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF0, 32'h0000_0000);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // asynchronous reset in the middle of an iteration
    @(posedge clock);
    start = 1'b1; op = 2'b00; opA = 32'd1234; opB = 32'd5678;
    repeat (6) @(posedge clock);
    start = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_flags", {60'd0, busy, stall, done, div_zero}, 64'd0);
    @(posedge clock);
    reset = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    run_op(2'b11, 32'd1000, 32'd33);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      run_op(ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
